fft_stage_ctrl: RTL and testbench
=================================

# fft_stage_ctrl

In-place radix-2 DIF FFT sequencer that drives a single registered radix-2 butterfly and a dual-port working memory. Generates per-stage butterfly read addresses, twiddle (coefficient ROM) addresses, matching write-back addresses, and the butterfly stall. Sits between the FFT top-level handshake and the butterfly/memory/ROM datapath.

## Interface
- LOG2N, 6, log2 of transform length N; N = 2**LOG2N, LOG2N >= 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a transform; ignored while busy.
- hold  input  1  global stall; freezes the controller and pipeline.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the transform completes.
- rd_en  output  1  memory read strobe for both butterfly operands.
- rd_addr_up  output  LOG2N  upper-leg read address.
- rd_addr_lo  output  LOG2N  lower-leg read address.
- coef_addr  output  LOG2N-1  twiddle ROM index, W_N^coef_addr.
- bf_stall  output  1  drives the butterfly stall input.
- wr_en  output  1  memory write strobe for both butterfly results.
- wr_addr_up  output  LOG2N  upper-result write address.
- wr_addr_lo  output  LOG2N  lower-result write address.
- out_valid  output  1  unload data valid (see Configuration).

## Operation
- FSM states: IDLE, RUN, DRAIN, UNLOAD (macro only), DONE.
- IDLE: start=1 and hold=0 -> RUN; stage s=0, butterfly counter j=0.
- RUN: each non-held cycle asserts rd_en for butterfly j of stage s, then j increments. After j=N/2-1 -> DRAIN.
- Address generation: span = N >> (s+1); k = j mod span; g = j div span; rd_addr_up = 2*g*span + k; rd_addr_lo = rd_addr_up + span; coef_addr = k << s.
- DRAIN: exactly 2 non-held cycles, enough for the last writes of the stage to commit. Exit: to RUN with s+1 and j=0 if s < LOG2N-1; otherwise to UNLOAD (macro) or DONE.
- DONE: done=1 for one cycle, then -> IDLE.
- Write-back pipeline: 2-deep shift of {valid, up, lo} addresses. It covers 1 cycle of memory read latency plus 1 cycle of butterfly register. wr_en and wr_addr_* correspond to the rd_en issued 2 non-held cycles earlier.
- hold=1: state, j, s, the write pipeline and the unload counter are all frozen. rd_en, wr_en and out_valid are forced to 0, and bf_stall=1. Otherwise bf_stall=0. The memory must hold its read data while rd_en=0.
- hold=1 coincident with start in IDLE: start is lost; the requester must re-pulse it.
- start while busy: ignored, no effect on any state.
- Address arithmetic is modulo 2**LOG2N with no saturation; j and s wrap are unreachable by construction.

## Timing
- Reset (rst_n=0, any time including mid-transform): state=IDLE, j=s=0, pipeline cleared. Every output is 0, including bf_stall. Recovery is on the first clk edge after release.
- start sampled at edge 0 -> first rd_en in cycle 1.
- Write latency: a read in cycle t produces its write in cycle t+2.
- Per stage: N/2 RUN cycles + 2 DRAIN cycles.
- Without hold: done rises in cycle LOG2N*(N/2+2)+1 (+N+1 with the macro).
- No read of stage s+1 occurs before the final write of stage s has committed.

## Configuration
- FFT_CTRL_BITREV_EN defined: after the last DRAIN, the FSM enters UNLOAD for N non-held cycles. Each cycle m sets rd_en=1, rd_addr_up = bit-reverse(m) and rd_addr_lo=0. out_valid follows each read 1 cycle later, and the 1-cycle latency tail is included before DONE. Result is natural-order output streaming.
- FFT_CTRL_BITREV_EN undefined: no UNLOAD state; out_valid is tied to 0. The result is left in memory in bit-reversed order.

## Test plan
- LOG2N=3, start at cycle 0, hold=0 -> stage 0 reads (up,lo,coef) = (0,4,0),(1,5,1),(2,6,2),(3,7,3) in cycles 1-4. Writes carry the same addresses in cycles 3-6.
- Same run -> stage 1 reads (0,2,0),(1,3,2),(4,6,0),(5,7,2) in cycles 7-10. Stage 2 reads (0,1,0),(2,3,0),(4,5,0),(6,7,0) in cycles 13-16. done=1 in cycle 19 only; busy high cycles 1-19.
- hold=1 in cycles 2-3 of stage 0 -> rd_en/wr_en=0 and bf_stall=1 in those cycles. The address sequence resumes unchanged and done shifts by exactly 2 cycles.
- start re-pulsed in cycle 8 while busy -> no change to addresses or done timing.
- rst_n=0 in cycle 9 -> all outputs 0 asynchronously. A new start after release restarts at stage 0, j=0.
- With FFT_CTRL_BITREV_EN, LOG2N=3 -> UNLOAD rd_addr_up = 0,4,2,6,1,5,3,7. out_valid is high for 8 cycles, one cycle behind the reads, then done.

Source files
------------

// File: rtl/fft_stage_ctrl_if.sv
// fft_stage_ctrl_if: handshake and datapath control bundle between the FFT sequencer and its butterfly/memory/ROM
interface fft_stage_ctrl_if #(parameter int LOG2N = 6);
  logic start, hold, busy, done, rd_en, bf_stall, wr_en, out_valid;
  logic [LOG2N-1:0] rd_addr_up, rd_addr_lo, wr_addr_up, wr_addr_lo;
  logic [LOG2N-2:0] coef_addr;
  modport master (
    input start, hold,
    output busy, done, rd_en, rd_addr_up, rd_addr_lo, coef_addr, bf_stall,
    output wr_en, wr_addr_up, wr_addr_lo, out_valid
  );
  modport slave (
    output start, hold,
    input busy, done, rd_en, rd_addr_up, rd_addr_lo, coef_addr, bf_stall,
    input wr_en, wr_addr_up, wr_addr_lo, out_valid
  );
endinterface

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: in-place radix-2 DIF FFT sequencer; FFT_CTRL_BITREV_EN adds a natural-order unload pass
module fft_stage_ctrl #(parameter int LOG2N = 6) (
  input logic clk,
  input logic rst_n,
  fft_stage_ctrl_if.master io
);
  localparam int SW = $clog2(LOG2N);
`ifdef FFT_CTRL_BITREV_EN
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, UNLOAD, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE} state_t;
`endif
  state_t state, nxt;
  logic [LOG2N-2:0] j, k;
  logic [SW-1:0] s, sh;
  logic d, last, run, unl_rd, ov;
  logic [LOG2N-1:0] jx, span, up, lo, br;
  logic [1:0] pv;
  logic [1:0][LOG2N-1:0] pu, pl;
  assign run = state == RUN;
  assign last = s == SW'(LOG2N-1);
  assign sh = SW'(LOG2N-1) - s;
  assign jx = {1'b0, j};
  assign span = LOG2N'(1) << sh;
  assign k = j & ~({(LOG2N-1){1'b1}} << sh);
  assign up = ((jx >> sh) << sh << 1) | {1'b0, k};
  assign lo = up | span;
`ifdef FFT_CTRL_BITREV_EN
  logic [LOG2N:0] m;
  assign unl_rd = state == UNLOAD && !m[LOG2N];
  // bit-reversed unload address
  always_comb begin
    br = '0;
    for (int i = 0; i < LOG2N; i++) br[i] = m[LOG2N-1-i];
  end
  // unload counter runs N reads plus one latency tail cycle; ov trails each read by one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m <= '0;
      ov <= 1'b0;
    end else if (!io.hold) begin
      m <= state == UNLOAD ? m + 1'b1 : '0;
      ov <= unl_rd;
    end
`else
  assign unl_rd = 1'b0;
  assign br = '0;
  assign ov = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next-state: everything is frozen while hold is high
  always_comb begin
    nxt = state;
    if (!io.hold)
      case (state)
        IDLE: nxt = io.start ? RUN : IDLE;
        RUN: nxt = &j ? DRAIN : RUN;
`ifdef FFT_CTRL_BITREV_EN
        DRAIN: nxt = !d ? DRAIN : !last ? RUN : UNLOAD;
        UNLOAD: nxt = m[LOG2N] ? DONE : UNLOAD;
`else
        DRAIN: nxt = !d ? DRAIN : !last ? RUN : DONE;
`endif
        DONE: nxt = IDLE;
        default: nxt = IDLE;
      endcase
  end
  // butterfly/stage counters and the 2-deep write-back address pipeline
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      j <= '0;
      s <= '0;
      d <= 1'b0;
      pv <= '0;
      pu <= '0;
      pl <= '0;
    end else if (!io.hold) begin
      j <= run ? j + 1'b1 : '0;
      d <= state == DRAIN ? ~d : 1'b0;
      s <= state == IDLE ? '0 : (state == DRAIN && d && !last) ? s + 1'b1 : s;
      pv <= {pv[0], run};
      pu <= {pu[0], up};
      pl <= {pl[0], lo};
    end
  assign io.busy = state != IDLE;
  assign io.done = state == DONE && !io.hold;
  assign io.bf_stall = io.hold & rst_n;
  assign io.rd_en = (run | unl_rd) & ~io.hold;
  assign io.rd_addr_up = run ? up : unl_rd ? br : '0;
  assign io.rd_addr_lo = run ? lo : '0;
  assign io.coef_addr = run ? k << s : '0;
  assign io.wr_en = pv[1] & ~io.hold;
  assign io.wr_addr_up = pv[1] ? pu[1] : '0;
  assign io.wr_addr_lo = pv[1] ? pl[1] : '0;
  assign io.out_valid = ov & ~io.hold;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb_fft_stage_ctrl: table-driven cycle checks with a write-back scoreboard for fft_stage_ctrl at LOG2N=3
module tb_fft_stage_ctrl;
  localparam int L = 3;
`ifdef FFT_CTRL_BITREV_EN
  localparam int DK = 27;
`else
  localparam int DK = 18;
`endif
  typedef struct {
    logic start, hold, busy, done, rd_en, wr_en, stall, ov, sb;
    logic [2:0] up, lo;
    logic [1:0] coef;
  } vec_t;
  typedef struct packed {logic [2:0] up, lo;} wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t tv[64];
  int nv;
  wr_t q[$];
  logic [2:0] eu[12], el[12], br[8];
  logic [1:0] ec[12];
  always #5 clk = ~clk;
  fft_stage_ctrl_if #(.LOG2N(L)) bus();
  fft_stage_ctrl #(.LOG2N(L)) dut(.clk(clk), .rst_n(rst_n), .io(bus));
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic chk_zero(input string t);
    chk({t, "_busy"}, 8'(bus.busy), 0);
    chk({t, "_done"}, 8'(bus.done), 0);
    chk({t, "_rd_en"}, 8'(bus.rd_en), 0);
    chk({t, "_rd_up"}, 8'(bus.rd_addr_up), 0);
    chk({t, "_rd_lo"}, 8'(bus.rd_addr_lo), 0);
    chk({t, "_coef"}, 8'(bus.coef_addr), 0);
    chk({t, "_stall"}, 8'(bus.bf_stall), 0);
    chk({t, "_wr_en"}, 8'(bus.wr_en), 0);
    chk({t, "_wr_up"}, 8'(bus.wr_addr_up), 0);
    chk({t, "_wr_lo"}, 8'(bus.wr_addr_lo), 0);
    chk({t, "_ov"}, 8'(bus.out_valid), 0);
  endtask
  function automatic void build(input int h0, input int h1, input int rs);
    int k = 0;
    int idx;
    logic held;
    vec_t v;
    nv = DK + 3 + (h1 >= h0 ? h1 - h0 + 1 : 0);
    for (int c = 0; c < nv; c++) begin
      v = '{default: 0};
      v.start = c == 0 || c == rs;
      if (c > 0) begin
        held = c >= h0 && c <= h1;
        v.hold = held;
        v.stall = held;
        v.busy = k <= DK;
        v.done = k == DK && !held;
        if (k < 18 && k % 6 < 4) begin
          idx = (k / 6) * 4 + k % 6;
          v.rd_en = !held;
          v.sb = !held;
          v.up = eu[idx];
          v.lo = el[idx];
          v.coef = ec[idx];
        end
        if (k >= 2 && k - 2 < 18 && (k - 2) % 6 < 4) v.wr_en = !held;
`ifdef FFT_CTRL_BITREV_EN
        if (k >= 18 && k < 26) begin
          v.rd_en = !held;
          v.up = br[k-18];
          v.lo = 3'd0;
        end
        if (k >= 19 && k <= 26) v.ov = !held;
`endif
        if (!held) k++;
      end
      tv[c] = v;
    end
  endfunction
  task automatic run_table(input string t);
    wr_t w;
    for (int c = 0; c < nv; c++) begin
      bus.start = tv[c].start;
      bus.hold = tv[c].hold;
      @(negedge clk);
      chk($sformatf("%s_busy@%0d", t, c), 8'(bus.busy), 8'(tv[c].busy));
      chk($sformatf("%s_done@%0d", t, c), 8'(bus.done), 8'(tv[c].done));
      chk($sformatf("%s_rd_en@%0d", t, c), 8'(bus.rd_en), 8'(tv[c].rd_en));
      chk($sformatf("%s_wr_en@%0d", t, c), 8'(bus.wr_en), 8'(tv[c].wr_en));
      chk($sformatf("%s_stall@%0d", t, c), 8'(bus.bf_stall), 8'(tv[c].stall));
      chk($sformatf("%s_ov@%0d", t, c), 8'(bus.out_valid), 8'(tv[c].ov));
      if (tv[c].rd_en) begin
        chk($sformatf("%s_rd_up@%0d", t, c), 8'(bus.rd_addr_up), 8'(tv[c].up));
        chk($sformatf("%s_rd_lo@%0d", t, c), 8'(bus.rd_addr_lo), 8'(tv[c].lo));
      end
      if (tv[c].sb) begin
        chk($sformatf("%s_coef@%0d", t, c), 8'(bus.coef_addr), 8'(tv[c].coef));
        q.push_back({tv[c].up, tv[c].lo});
      end
      if (bus.wr_en) begin
        if (q.size() == 0) chk($sformatf("%s_wr_unexpected@%0d", t, c), 8'(bus.wr_en), 0);
        else begin
          w = q.pop_front();
          chk($sformatf("%s_wr_up@%0d", t, c), 8'(bus.wr_addr_up), 8'(w.up));
          chk($sformatf("%s_wr_lo@%0d", t, c), 8'(bus.wr_addr_lo), 8'(w.lo));
        end
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.hold = 1'b0;
    chk({t, "_sb_left"}, 8'(q.size()), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    eu = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    el = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    ec = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
    br = '{0, 4, 2, 6, 1, 5, 3, 7};
    bus.start = 1'b0;
    bus.hold = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("in_reset");
    bus.hold = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    build(1, 0, -1);
    run_table("plain");
    build(1, 0, 8);
    run_table("restart_busy");
    build(2, 3, -1);
    run_table("hold");
    bus.hold = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    chk("lost_start_stall", 8'(bus.bf_stall), 1);
    @(posedge clk);
    #1;
    bus.hold = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("lost_start_busy", 8'(bus.busy), 0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("pre_reset_rd_en", 8'(bus.rd_en), 1);
    chk("pre_reset_rd_up", 8'(bus.rd_addr_up), 8'(eu[6]));
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    build(1, 0, -1);
    run_table("after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
